// File: rtl/grey_disp_pkg.sv
// Shared constants for the Grey-coded scan display: digit codes,
// 7-segment patterns and the slot index encoding.
package grey_disp_pkg;

  localparam logic [4:0] GREY_0 = 5'b00000;
  localparam logic [4:0] GREY_1 = 5'b00001;
  localparam logic [4:0] GREY_2 = 5'b00011;
  localparam logic [4:0] GREY_3 = 5'b00010;
  localparam logic [4:0] GREY_4 = 5'b00110;
  localparam logic [4:0] GREY_5 = 5'b00100;
  localparam logic [4:0] GREY_6 = 5'b01100;
  localparam logic [4:0] GREY_7 = 5'b01000;
  localparam logic [4:0] GREY_8 = 5'b11000;
  localparam logic [4:0] GREY_9 = 5'b10000;

  // Segments ordered {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    SLOT_THOU = 2'd0,
    SLOT_HUND = 2'd1,
    SLOT_TENS = 2'd2,
    SLOT_ONES = 2'd3
  } slot_e;

  function automatic slot_e next_slot(input slot_e s);
    case (s)
      SLOT_THOU: return SLOT_HUND;
      SLOT_HUND: return SLOT_TENS;
      SLOT_TENS: return SLOT_ONES;
      default:   return SLOT_THOU;
    endcase
  endfunction

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/grey_scan_display_if.sv
// Digit inputs and display-pin outputs of the scan display.
interface grey_scan_display_if;
  logic [4:0] i_thou;
  logic [4:0] i_hund;
  logic [4:0] i_tens;
  logic [4:0] i_ones;
  logic       i_lz_en;
  logic [6:0] o_seg;
  logic [3:0] o_digit_sel;
  logic       o_err;

  modport master (
    output i_thou, i_hund, i_tens, i_ones, i_lz_en,
    input  o_seg, o_digit_sel, o_err
  );

  modport slave (
    input  i_thou, i_hund, i_tens, i_ones, i_lz_en,
    output o_seg, o_digit_sel, o_err
  );
endinterface

// File: rtl/grey_to_bcd.sv
// Combinational Grey-code digit decoder; flags codes outside the table.
module grey_to_bcd
  import grey_disp_pkg::*;
(
  input  logic [4:0] i_grey,
  output logic [3:0] o_bcd,
  output logic       o_valid
);

  // Table lookup; unknown codes report invalid with BCD 0
  always_comb begin
    o_bcd   = 4'd0;
    o_valid = 1'b1;
    case (i_grey)
      GREY_0:  o_bcd = 4'd0;
      GREY_1:  o_bcd = 4'd1;
      GREY_2:  o_bcd = 4'd2;
      GREY_3:  o_bcd = 4'd3;
      GREY_4:  o_bcd = 4'd4;
      GREY_5:  o_bcd = 4'd5;
      GREY_6:  o_bcd = 4'd6;
      GREY_7:  o_bcd = 4'd7;
      GREY_8:  o_bcd = 4'd8;
      GREY_9:  o_bcd = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/grey_scan_display.sv
// Four-digit multiplexed 7-segment driver for Grey-coded digits with
// per-frame snapshot, inter-digit blanking, leading-zero suppression
// and a sticky invalid-code flag.
module grey_scan_display
  import grey_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1024,
  parameter int unsigned BLANK_CYC = 16
) (
  input logic           i_clk,
  input logic           i_rst_n,
  grey_scan_display_if.slave disp
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_e            idx_q, idx_d;
  logic [4:0]       thou_q, thou_d, hund_q, hund_d;
  logic [4:0]       tens_q, tens_d, ones_q, ones_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       sel_q, sel_d;
  logic             err_q, err_d;

  logic [4:0]       cur_grey;
  logic [3:0]       cur_bcd;
  logic             cur_valid;
  logic             blank_slot;
  logic [3:0]       onehot;

  // Prescaler, slot advance and end-of-frame snapshot of all four digits
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    thou_d = thou_q;
    hund_d = hund_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = next_slot(idx_q);
      if (idx_q == SLOT_ONES) begin
        thou_d = disp.i_thou;
        hund_d = disp.i_hund;
        tens_d = disp.i_tens;
        ones_d = disp.i_ones;
      end
    end
  end

  // Select the current slot's shadow digit and its leading-zero blanking
  always_comb begin
    cur_grey   = ones_q;
    blank_slot = 1'b0;
    onehot     = 4'b0001;
    case (idx_q)
      SLOT_THOU: begin
        cur_grey   = thou_q;
        blank_slot = disp.i_lz_en && (thou_q == GREY_0);
        onehot     = 4'b1000;
      end
      SLOT_HUND: begin
        cur_grey   = hund_q;
        blank_slot = disp.i_lz_en && (thou_q == GREY_0) && (hund_q == GREY_0);
        onehot     = 4'b0100;
      end
      SLOT_TENS: begin
        cur_grey   = tens_q;
        blank_slot = disp.i_lz_en && (thou_q == GREY_0) && (hund_q == GREY_0)
                     && (tens_q == GREY_0);
        onehot     = 4'b0010;
      end
      default: begin
        cur_grey   = ones_q;
        blank_slot = 1'b0;
        onehot     = 4'b0001;
      end
    endcase
  end

  grey_to_bcd u_grey_to_bcd (
    .i_grey  (cur_grey),
    .o_bcd   (cur_bcd),
    .o_valid (cur_valid)
  );

  // Next display-pin values; error latches only when a dash is actually shown
  always_comb begin
    sel_d = '0;
    seg_d = SEG_OFF;
    err_d = err_q;
    if (cnt_q >= BLANK_END) begin
      sel_d = onehot;
      if (!blank_slot) begin
        seg_d = cur_valid ? bcd_to_seg(cur_bcd) : SEG_DASH;
        err_d = err_q | ~cur_valid;
      end
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      idx_q  <= SLOT_THOU;
      thou_q <= '0;
      hund_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
      seg_q  <= SEG_OFF;
      sel_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      thou_q <= thou_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
    end
  end

  assign disp.o_seg       = seg_q;
  assign disp.o_digit_sel = sel_q;
  assign disp.o_err       = err_q;

endmodule

// File: tb/tb_grey_scan_display.sv
// Directed bench for grey_scan_display with SCAN_DIV=8, BLANK_CYC=2.
module tb_grey_scan_display;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 i_clk = ~i_clk;

  grey_scan_display_if dif ();

  grey_scan_display #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .disp    (dif.slave)
  );

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One 8-clock slot: 2 blank clocks then 6 active clocks
  task automatic run_slot(input string tag, input logic [3:0] sel, input logic [6:0] seg,
                          input logic err_pre, input logic err_post);
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk);
      #1;
      if (i < 2) begin
        chk({tag, " sel"}, {3'b0, dif.o_digit_sel}, 7'h00);
        chk({tag, " seg"}, dif.o_seg, 7'h00);
        chk({tag, " err"}, {6'b0, dif.o_err}, {6'b0, err_pre});
      end else begin
        chk({tag, " sel"}, {3'b0, dif.o_digit_sel}, {3'b0, sel});
        chk({tag, " seg"}, dif.o_seg, seg);
        chk({tag, " err"}, {6'b0, dif.o_err}, {6'b0, err_post});
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0, input logic err);
    run_slot({tag, " thou"}, 4'b1000, s3, err, err);
    run_slot({tag, " hund"}, 4'b0100, s2, err, err);
    run_slot({tag, " tens"}, 4'b0010, s1, err, err);
    run_slot({tag, " ones"}, 4'b0001, s0, err, err);
  endtask

  initial begin
    dif.i_thou  = 5'b00000;
    dif.i_hund  = 5'b00000;
    dif.i_tens  = 5'b00000;
    dif.i_ones  = 5'b00000;
    dif.i_lz_en = 1'b0;
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("reset seg", dif.o_seg, 7'h00);
    chk("reset sel", {3'b0, dif.o_digit_sel}, 7'h00);
    chk("reset err", {6'b0, dif.o_err}, 7'h00);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Frame 1: zero shadows, no suppression; load the next number now
    dif.i_hund = 5'b00001;
    dif.i_tens = 5'b00011;
    dif.i_ones = 5'b10000;
    run_frame("f1", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
    dif.i_lz_en = 1'b1;

    // Frame 2: 0129 with leading-zero blanking
    run_frame("f2", 7'h00, 7'h06, 7'h5B, 7'h6F, 1'b0);

    // Frame 3: ones input changes mid-frame but shadow holds 9
    run_slot("f3 thou", 4'b1000, 7'h00, 1'b0, 1'b0);
    dif.i_ones = 5'b11000;
    run_slot("f3 hund", 4'b0100, 7'h06, 1'b0, 1'b0);
    run_slot("f3 tens", 4'b0010, 7'h5B, 1'b0, 1'b0);
    run_slot("f3 ones", 4'b0001, 7'h6F, 1'b0, 1'b0);

    // Frame 4: new ones digit 8; load an invalid tens code
    run_slot("f4 thou", 4'b1000, 7'h00, 1'b0, 1'b0);
    dif.i_tens = 5'b11111;
    run_slot("f4 hund", 4'b0100, 7'h06, 1'b0, 1'b0);
    run_slot("f4 tens", 4'b0010, 7'h5B, 1'b0, 1'b0);
    run_slot("f4 ones", 4'b0001, 7'h7F, 1'b0, 1'b0);

    // Frame 5: dash in tens slot raises the sticky error
    run_slot("f5 thou", 4'b1000, 7'h00, 1'b0, 1'b0);
    run_slot("f5 hund", 4'b0100, 7'h06, 1'b0, 1'b0);
    run_slot("f5 tens", 4'b0010, 7'h40, 1'b0, 1'b1);
    dif.i_tens = 5'b00011;
    run_slot("f5 ones", 4'b0001, 7'h7F, 1'b1, 1'b1);

    // Frame 6: valid again, error stays set; load all zeros
    run_slot("f6 thou", 4'b1000, 7'h00, 1'b1, 1'b1);
    dif.i_hund = 5'b00000;
    dif.i_tens = 5'b00000;
    dif.i_ones = 5'b00000;
    run_slot("f6 hund", 4'b0100, 7'h06, 1'b1, 1'b1);
    run_slot("f6 tens", 4'b0010, 7'h5B, 1'b1, 1'b1);
    run_slot("f6 ones", 4'b0001, 7'h7F, 1'b1, 1'b1);

    // Frame 7: all zeros under suppression, only ones lit
    run_frame("f7", 7'h00, 7'h00, 7'h00, 7'h3F, 1'b1);

    // Frame 8: reset asynchronously part-way into the tens slot
    run_slot("f8 thou", 4'b1000, 7'h00, 1'b1, 1'b1);
    run_slot("f8 hund", 4'b0100, 7'h00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk);
      #1;
    end
    chk("pre-rst sel", {3'b0, dif.o_digit_sel}, 7'h02);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async rst seg", dif.o_seg, 7'h00);
    chk("async rst sel", {3'b0, dif.o_digit_sel}, 7'h00);
    chk("async rst err", {6'b0, dif.o_err}, 7'h00);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Restart at thou with zero shadows
    run_frame("post-rst", 7'h00, 7'h00, 7'h00, 7'h3F, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
